// File: rtl/alu_seq_pkg.sv
// Shared encodings for alu_seq: instruction-type codes, funct3/funct7 values,
// FSM states and the M-extension operation enum.
package alu_seq_pkg;

    localparam logic [2:0] IT_R = 3'd0;
    localparam logic [2:0] IT_I = 3'd1;
    localparam logic [2:0] IT_S = 3'd2;
    localparam logic [2:0] IT_B = 3'd3;
    localparam logic [2:0] IT_U = 3'd4;
    localparam logic [2:0] IT_J = 3'd5;
    localparam logic [2:0] IT_N = 3'd7;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_op_e;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Radix-2 iterative multiply/divide: one shift-add or restoring-subtract step per
// cycle on operand magnitudes, signs restored on the final step.
module alu_muldiv_iter
    import alu_seq_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            start,
    input  md_op_e          op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN);

    logic              run_q;
    logic [CNT_W-1:0]  cnt_q;
    md_op_e            op_q;
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [XLEN-1:0]   opb_q;
    logic [XLEN-1:0]   a_q;
    logic              neg_q, neg_rem_q, div0_q;

    logic              sgn_a, sgn_b;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [XLEN:0]     psum, shl, diff;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s, rem_s;

    always_comb begin
        sgn_a = a[XLEN-1] && (op == MD_MULH || op == MD_MULHSU || op == MD_DIV || op == MD_REM);
        sgn_b = b[XLEN-1] && (op == MD_MULH || op == MD_DIV || op == MD_REM);
        mag_a = sgn_a ? -a : a;
        mag_b = sgn_b ? -b : b;
    end

    // shift-add multiply and restoring divide step; diff[XLEN] is the borrow
    always_comb begin
        psum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, opb_q} : '0);
        prod_d = {psum, prod_q[XLEN-1:1]};
        shl    = {rem_q, quo_q[XLEN-1]};
        diff   = shl - {1'b0, opb_q};
        if (!diff[XLEN]) begin
            rem_d = diff[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b1};
        end else begin
            rem_d = shl[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b0};
        end
    end

    always_comb begin
        prod_s = neg_q ? -prod_d : prod_d;
        quo_s  = neg_q ? -quo_d : quo_d;
        rem_s  = neg_rem_q ? -rem_d : rem_d;
        result = '0;
        case (op_q)
            MD_MUL:                         result = prod_s[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU:   result = prod_s[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:                result = div0_q ? '1 : quo_s;
            MD_REM, MD_REMU:                result = div0_q ? a_q : rem_s;
            default:                        result = '0;
        endcase
    end

    assign done = run_q && (cnt_q == CNT_W'(XLEN - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            run_q <= 1'b0;
            cnt_q <= '0;
        end else if (start) begin
            run_q <= 1'b1;
            cnt_q <= '0;
        end else if (run_q) begin
            if (done) begin
                run_q <= 1'b0;
            end
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            op_q      <= op;
            prod_q    <= {{XLEN{1'b0}}, mag_a};
            rem_q     <= '0;
            quo_q     <= mag_a;
            opb_q     <= mag_b;
            a_q       <= a;
            neg_q     <= sgn_a ^ sgn_b;
            neg_rem_q <= sgn_a;
            div0_q    <= (b == '0);
        end else if (run_q) begin
            prod_q <= prod_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential RISC-V ALU with valid/ready handshake; define ALU_SEQ_MULDIV_EN to add
// the iterative M-extension unit (XLEN busy cycles per mul/div).
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      funct3_,
    input  logic [6:0]      funct7_,
    input  logic [2:0]      instr_type,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] c,
    output logic            illegal,
    output logic            busy
);

    state_e                 state_q, state_d;
    logic [XLEN-1:0]        c_q, c_d;
    logic                   ill_q, ill_d;
    logic                   accept, is_md, md_done;
    logic [XLEN-1:0]        md_result;
    logic [XLEN-1:0]        alu_c;
    logic                   alu_ill;
    logic [SHAMT_W-1:0]     shamt;
    logic signed [XLEN-1:0] a_s, b_s, sra_s;

    assign shamt = b[SHAMT_W-1:0];
    assign a_s   = a;
    assign b_s   = b;
    assign sra_s = a_s >>> shamt;

    always_comb begin
        alu_c   = '0;
        alu_ill = 1'b0;
        case (instr_type)
            IT_R, IT_I: begin
                if (funct7_ == F7_BASE) begin
                    case (funct3_)
                        F3_ADD:  alu_c = a + b;
                        F3_SLL:  alu_c = a << shamt;
                        F3_SLT:  alu_c = XLEN'(a_s < b_s);
                        F3_SLTU: alu_c = XLEN'(a < b);
                        F3_XOR:  alu_c = a ^ b;
                        F3_SR:   alu_c = a >> shamt;
                        F3_OR:   alu_c = a | b;
                        default: alu_c = a & b;
                    endcase
                end else if (funct7_ == F7_ALT && funct3_ == F3_ADD) begin
                    alu_c = a - b;
                end else if (funct7_ == F7_ALT && funct3_ == F3_SR) begin
                    alu_c = sra_s;
                end else begin
                    alu_ill = 1'b1;
                end
            end
            IT_B: begin
                case (funct3_)
                    F3_BEQ:  alu_c = XLEN'(a == b);
                    F3_BNE:  alu_c = XLEN'(a != b);
                    F3_BLT:  alu_c = XLEN'(a_s < b_s);
                    F3_BGE:  alu_c = XLEN'(a_s >= b_s);
                    F3_BLTU: alu_c = XLEN'(a < b);
                    F3_BGEU: alu_c = XLEN'(a >= b);
                    default: alu_ill = 1'b1;
                endcase
            end
            IT_S, IT_J: alu_c = a + b;
            IT_U:       alu_c = b;
            IT_N:       alu_c = '0;
            default:    alu_ill = 1'b1;
        endcase
    end

`ifdef ALU_SEQ_MULDIV_EN
    logic   md_start;
    md_op_e md_op;

    assign is_md    = (instr_type == IT_R) && (funct7_ == F7_MULDIV);
    assign md_start = accept && is_md;
    assign md_op    = md_op_e'(funct3_);

    alu_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (flush),
        .start  (md_start),
        .op     (md_op),
        .a      (a),
        .b      (b),
        .done   (md_done),
        .result (md_result)
    );
`else
    assign is_md     = 1'b0;
    assign md_done   = 1'b0;
    assign md_result = '0;
`endif

    // flush blocks any accept in the cycle it is raised
    assign in_ready = !flush && (state_q == IDLE || (state_q == DONE && out_ready));
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (accept) state_d = is_md ? BUSY : DONE;
                BUSY: if (md_done) state_d = DONE;
                DONE: begin
                    if (accept) begin
                        state_d = is_md ? BUSY : DONE;
                    end else if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        out_valid = (state_q == DONE);
        busy      = (state_q == BUSY);
    end

    always_comb begin
        c_d   = c_q;
        ill_d = ill_q;
        if (!flush) begin
            if (accept && !is_md) begin
                c_d   = alu_c;
                ill_d = alu_ill;
            end else if (state_q == BUSY && md_done) begin
                c_d   = md_result;
                ill_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            c_q   <= '0;
            ill_q <= 1'b0;
        end else begin
            c_q   <= c_d;
            ill_q <= ill_d;
        end
    end

    assign c       = c_q;
    assign illegal = ill_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed + randomized bench for alu_seq (XLEN=32) against an arithmetic reference
// model; M-extension checks are compiled in when ALU_SEQ_MULDIV_EN is defined.
module tb_alu_seq;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] a, b;
    logic [2:0]      funct3_;
    logic [6:0]      funct7_;
    logic [2:0]      instr_type;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] c;
    logic            illegal;
    logic            busy;

    int n_cmp = 0;
    int n_mis = 0;

    alu_seq #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .funct3_    (funct3_),
        .funct7_    (funct7_),
        .instr_type (instr_type),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .c          (c),
        .illegal    (illegal),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] md_ref(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
        longint          sx = longint'(int'(x));
        longint          sy = longint'(int'(y));
        longint          uy = longint'({32'd0, y});
        longint unsigned ux = {32'd0, x};
        longint unsigned uyy = {32'd0, y};
        longint          p;
        longint unsigned up;
        case (f3)
            3'd0: begin p = sx * sy; return p[31:0]; end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * uy; return p[63:32]; end
            3'd3: begin up = ux * uyy; return up[63:32]; end
            3'd4: begin if (y == 0) return 32'hFFFF_FFFF; p = sx / sy; return p[31:0]; end
            3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: begin if (y == 0) return x; p = sx % sy; return p[31:0]; end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    // expected result, illegal flag and whether the op is iterative
    task automatic model(input logic [2:0] it, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] rc, output logic rill, output logic rmd);
        int sx, sy;
        int sh;
        sx = int'(x);
        sy = int'(y);
        sh = int'(y % 32);
        rc = 0; rill = 0; rmd = 0;
        if (it == 3'd0 || it == 3'd1) begin
            if (it == 3'd0 && f7 == 7'h01) begin
`ifdef ALU_SEQ_MULDIV_EN
                rmd = 1; rc = md_ref(f3, x, y);
`else
                rill = 1;
`endif
            end else if (f7 == 7'h00) begin
                case (f3)
                    3'd0: rc = x + y;
                    3'd1: rc = x << sh;
                    3'd2: rc = (sx < sy) ? 1 : 0;
                    3'd3: rc = (x < y) ? 1 : 0;
                    3'd4: rc = x ^ y;
                    3'd5: rc = x >> sh;
                    3'd6: rc = x | y;
                    default: rc = x & y;
                endcase
            end else if (f7 == 7'h20 && f3 == 3'd0) rc = x - y;
            else if (f7 == 7'h20 && f3 == 3'd5) rc = sx >>> sh;
            else rill = 1;
        end else if (it == 3'd3) begin
            case (f3)
                3'd0: rc = (x == y) ? 1 : 0;
                3'd1: rc = (x != y) ? 1 : 0;
                3'd4: rc = (sx < sy) ? 1 : 0;
                3'd5: rc = (sx >= sy) ? 1 : 0;
                3'd6: rc = (x < y) ? 1 : 0;
                3'd7: rc = (x >= y) ? 1 : 0;
                default: rill = 1;
            endcase
        end else if (it == 3'd2 || it == 3'd5) rc = x + y;
        else if (it == 3'd4) rc = y;
        else if (it == 3'd7) rc = 0;
        else rill = 1;
    endtask

    task automatic present(input logic [2:0] it, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [31:0] x, input logic [31:0] y);
        instr_type = it; funct3_ = f3; funct7_ = f7; a = x; b = y; in_valid = 1'b1;
    endtask

    // issue one op from IDLE, check latency, busy count, result, then drain
    task automatic run_op(input string tag, input logic [2:0] it, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] ec;
        logic        eill, emd;
        int          lat, nbusy;
        model(it, f3, f7, x, y, ec, eill, emd);
        out_ready = 1'b0;
        present(it, f3, f7, x, y);
        check({tag, " in_ready"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        lat = 1;
        nbusy = 0;
        while (!out_valid && lat < 200) begin
            if (busy) nbusy++;
            tick();
            lat++;
        end
        check({tag, " latency"}, lat, emd ? XLEN + 1 : 1);
        check({tag, " busy_cycles"}, nbusy, emd ? XLEN : 0);
        check({tag, " c"}, c, ec);
        check({tag, " illegal"}, illegal, eill);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " drained"}, out_valid, 0);
    endtask

    initial begin
        logic [31:0] cor [0:5];
        logic [31:0] ra, rb;
        logic [6:0]  rf7;
        int          sel;
        logic        seen_valid;
        cor[0] = 32'h0; cor[1] = 32'h8000_0000; cor[2] = 32'hFFFF_FFFF;
        cor[3] = 32'h7FFF_FFFF; cor[4] = 32'h1; cor[5] = 32'h1F;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        a = 0; b = 0; funct3_ = 0; funct7_ = 0; instr_type = 0;
        repeat (3) tick();
        check("reset c", c, 0);
        check("reset illegal", illegal, 0);
        check("reset out_valid", out_valid, 0);
        check("reset busy", busy, 0);
        rst_n = 1'b1;

        // first accept right after reset release
        run_op("add_7_m3", 3'd0, 3'd0, 7'h00, 32'd7, 32'hFFFF_FFFD);

        // SRAI, then result held while consumer stalls
        present(3'd1, 3'd5, 7'h20, 32'h8000_0000, 32'd4);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("srai c held", c, 32'hF800_0000);
            check("srai valid held", out_valid, 1);
            tick();
        end
        check("srai illegal", illegal, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("srai drained", out_valid, 0);

        // back-to-back accepts with no bubble
        out_ready = 1'b1;
        present(3'd0, 3'd4, 7'h00, 32'h0000_F0F0, 32'h0000_0FF0);
        tick();
        present(3'd1, 3'd3, 7'h00, 32'd1, 32'd2);
        check("b2b first valid", out_valid, 1);
        check("b2b first c", c, 32'h0000_FF00);
        check("b2b ready in done", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("b2b second valid", out_valid, 1);
        check("b2b second c", c, 1);
        tick();
        check("b2b idle", out_valid, 0);
        out_ready = 1'b0;

        // illegal encodings
`ifdef ALU_SEQ_MULDIV_EN
        run_op("r_f7_bad", 3'd0, 3'd0, 7'h02, 32'd3, 32'd4);
`else
        run_op("r_f7_muldiv_off", 3'd0, 3'd0, 7'h01, 32'd3, 32'd4);
`endif
        run_op("type6", 3'd6, 3'd0, 7'h00, 32'd3, 32'd4);
        run_op("b_f3_010", 3'd3, 3'd2, 7'h00, 32'd3, 32'd3);
        run_op("i_xor_alt", 3'd1, 3'd4, 7'h20, 32'd3, 32'd4);
        run_op("bge_neg", 3'd3, 3'd5, 7'h00, 32'hFFFF_FFFF, 32'd0);
        run_op("bgeu_neg", 3'd3, 3'd7, 7'h00, 32'd0, 32'hFFFF_FFFF);
        run_op("lui", 3'd4, 3'd0, 7'h00, 32'd9, 32'h1234_5000);
        run_op("store", 3'd2, 3'd0, 7'h00, 32'hFFFF_FFFF, 32'd2);

        // flush from DONE overrides a pending handshake and new request
        present(3'd0, 3'd6, 7'h00, 32'h00F0, 32'h000F);
        tick();
        check("flush pre valid", out_valid, 1);
        flush = 1'b1;
        out_ready = 1'b1;
        check("flush blocks ready", in_ready, 0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush valid low", out_valid, 0);
        tick();
        check("flush no accept", out_valid, 0);
        out_ready = 1'b0;

        // reset while holding a result in DONE
        present(3'd0, 3'd0, 7'h00, 32'd10, 32'd20);
        tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst_done c", c, 0);
        check("rst_done valid", out_valid, 0);

`ifdef ALU_SEQ_MULDIV_EN
        run_op("div_by_0", 3'd0, 3'd4, 7'h01, 32'd5, 32'd0);
        run_op("rem_ovf", 3'd0, 3'd6, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("div_ovf", 3'd0, 3'd4, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("mulhu_max", 3'd0, 3'd3, 7'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // flush at BUSY cycle 10
        present(3'd0, 3'd5, 7'h01, 32'd1000, 32'd7);
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        check("md busy before flush", busy, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("md flush busy", busy, 0);
        seen_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen_valid = 1'b1;
            tick();
        end
        check("md flush never valid", seen_valid, 0);

        // reset mid-BUSY (c holds the earlier MULHU result)
        present(3'd0, 3'd0, 7'h01, 32'd6, 32'd7);
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("md rst c", c, 0);
        check("md rst busy", busy, 0);
        check("md rst valid", out_valid, 0);
        check("md rst illegal", illegal, 0);
        repeat (40) tick();
        check("md rst stays idle", out_valid, 0);
`endif

        for (int n = 0; n < 60; n++) begin
            ra = ($urandom_range(0, 3) == 0) ? cor[$urandom_range(0, 5)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? cor[$urandom_range(0, 5)] : $urandom;
            sel = $urandom_range(0, 9);
            if (sel < 6) rf7 = 7'h00;
            else if (sel < 8) rf7 = 7'h20;
            else if (sel == 8) rf7 = 7'h01;
            else rf7 = 7'($urandom);
            run_op($sformatf("rnd%0d", n), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), rf7, ra, rb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter XLEN, default 32, datapath width in bits; legal values 32 and 64.
REQ-002 Parameter SHAMT_W, default $clog2(XLEN), width of the shift-amount field taken from b.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 in_valid  input  1  operation request valid.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 a, b  input  XLEN  operands; b carries rs2 or the immediate.
REQ-008 funct3_  input  3  RISC-V funct3; funct7_  input  7  RISC-V funct7.
REQ-009 instr_type  input  3  R=0, I=1, S=2, B=3, U=4, J=5, N=7; other codes are unknown.
REQ-010 flush  input  1  abort any in-flight operation.
REQ-011 out_valid  output  1  result valid; out_ready  input  1  consumer accepts the result.
REQ-012 c  output  XLEN  result; illegal  output  1  the request decoded to no supported operation.
REQ-013 busy  output  1  high while an iterative operation is executing.

Function
REQ-014 FSM states: IDLE, BUSY, DONE; the request is accepted when in_valid && in_ready.
REQ-015 in_ready = (state==IDLE) || (state==DONE && out_ready); an accept in DONE completes the old handshake and starts the new operation in the same cycle.
REQ-016 Single-cycle ops (all R/I base ops, S, B, U, J, N): c and illegal are registered at accept, the FSM enters DONE, and out_valid rises on the next cycle.
REQ-017 R/I: ADD/SUB, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND; shifts use b[SHAMT_W-1:0]; SUB/SRA are selected by funct7_=0100000; any other funct7_ gives c=0 with illegal=1.
REQ-018 B: c=1 when the condition holds, else 0, for BEQ, BNE, BLT, BGE, BLTU, BGEU; funct3_ 010/011 gives c=0 with illegal=1.
REQ-019 S, J: c=a+b (mod 2^XLEN); U: c=b; N: c=0; an unknown instr_type gives c=0 with illegal=1.
REQ-020 In DONE, c, out_valid and illegal hold stable until out_ready; then the FSM goes to IDLE, or to the next operation per REQ-015.
REQ-021 flush has priority over every other event except reset: the next state is IDLE, out_valid=0 and busy=0 next cycle, in_ready is forced to 0 during the flush cycle, and any result is discarded.
REQ-022 Results are wrap-around modulo 2^XLEN; no output flags overflow.

Reset
REQ-023 When rst_n=0 at a clock edge: state=IDLE, c=0, out_valid=0, illegal=0, busy=0, and the iteration counter=0; this holds even mid-BUSY or mid-DONE.
REQ-024 The first accept is possible in the first cycle after rst_n returns high.

Configuration
REQ-025 Macro ALU_SEQ_MULDIV_EN, when defined, adds RV M-extension ops: R-type with funct7_=0000001, funct3_ 000-111 = MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
REQ-026 With the macro defined: accept enters BUSY with busy=1 for exactly XLEN cycles (radix-2 iteration), then DONE, so out_valid rises XLEN+1 cycles after accept.
REQ-027 Division by zero: quotient is all ones and remainder equals the dividend; signed overflow (-2^(XLEN-1) / -1): quotient equals the dividend and remainder is 0.
REQ-028 With the macro undefined, funct7_=0000001 takes the single-cycle path with c=0 and illegal=1, and no BUSY state or iteration logic is synthesised.

Structure
REQ-029 Package alu_seq_pkg holds the instr_type codes, the funct3/funct7 constants, the FSM state enum and the M-extension op enum.
REQ-030 The iterative multiply/divide sits in one sub-module, alu_muldiv_iter (start, op, a, b, done, result), instantiated only under ALU_SEQ_MULDIV_EN.

Verification
REQ-031 XLEN=32, R ADD a=7 b=-3 -> out_valid one cycle after accept, c=4, illegal=0.
REQ-032 I SRAI a=0x80000000, b=4, funct7_=0100000 -> c=0xF8000000; then out_ready=0 for 5 cycles -> c stable and out_valid held.
REQ-033 Back-to-back: two ops with out_ready=1 throughout -> second accept on the DONE cycle of the first, with no bubble.
REQ-034 MULDIV_EN: DIV a=5 b=0 -> c=0xFFFFFFFF at accept+33; REM a=0x80000000 b=-1 -> c=0; MULHU a=b=0xFFFFFFFF -> c=0xFFFFFFFE.
REQ-035 MULDIV_EN: flush at BUSY cycle 10 -> IDLE next cycle with out_valid never rising; repeat with rst_n=0 mid-BUSY -> all outputs 0.
REQ-036 R funct7_=0000001 with the macro undefined, and instr_type=6 -> c=0, illegal=1.
